// File: rtl/lcd_bcd_counter_drv.sv
// lcd_bcd_counter_drv
//   N-digit BCD up/down counter driving a static (direct-drive) LCD.
//   A single clock is used throughout. The count rate and the LCD common
//   frequency come from clock-enable prescalers, not from derived clocks.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   en         count enable; when low, the count prescaler and counter hold
//   up         count direction (1 = increment), sampled on the tick cycle
//   load       synchronous parallel load; has priority over a tick
//   load_val   BCD load value, digit k in [4k+3:4k]; nibbles >9 load as 0
//   blank_lz   enables leading-zero blanking (digit 0 is never blanked)
//   bcd_out    current count, digit 0 least significant
//   carry      one-cycle pulse on wrap (99..9->0 up, 0->99..9 down)
//   lcdcom     LCD common drive, square wave with period 2*COM_DIV
//   lcdseg     segments of digit k in [7k+6:7k], XORed with lcdcom
module lcd_bcd_counter_drv #(
  parameter int DIGITS  = 3,
  parameter int CNT_DIV = 2048,
  parameter int COM_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  carry,
  output logic                  lcdcom,
  output logic [7*DIGITS-1:0]   lcdseg
);

  localparam int PW = $clog2(CNT_DIV);
  localparam int CW = (COM_DIV > 1) ? $clog2(COM_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(CNT_DIV - 1);
  localparam logic [CW-1:0] CDIV_MAX = CW'(COM_DIV - 1);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                carry_q, carry_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [CW-1:0]       cdiv_q, cdiv_d;
  logic                lcdcom_q, lcdcom_d;

  logic                tick;
  logic                wrap;
  logic [4*DIGITS-1:0] step_val;
  logic [4*DIGITS-1:0] load_clean;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h79;
    endcase
  endfunction

  // Ripple increment/decrement across digits. The carry/borrow out of the
  // top digit is the wrap indication.
  always_comb begin : p_step
    logic       c;
    logic [3:0] dig;
    c        = 1'b1;
    dig      = 4'd0;
    step_val = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      dig = bcd_q[4*k +: 4];
      if (c) begin
        if (up) begin
          if (dig >= 4'd9) begin
            step_val[4*k +: 4] = 4'd0;
          end else begin
            step_val[4*k +: 4] = dig + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*k +: 4] = 4'd9;
          end else begin
            step_val[4*k +: 4] = dig - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    wrap = c;
  end

  // Non-BCD nibbles are stored as 0 so the counter never holds an illegal digit.
  always_comb begin
    load_clean = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] <= 4'd9) load_clean[4*k +: 4] = load_val[4*k +: 4];
    end
  end

  always_comb begin
    tick     = en & (pre_q == PRE_MAX);
    bcd_d    = bcd_q;
    pre_d    = pre_q;
    carry_d  = 1'b0;
    cdiv_d   = cdiv_q + CW'(1);
    lcdcom_d = lcdcom_q;

    if (cdiv_q == CDIV_MAX) begin
      cdiv_d   = '0;
      lcdcom_d = ~lcdcom_q;
    end

    // A tick coinciding with load is dropped.
    if (load) begin
      bcd_d = load_clean;
      pre_d = '0;
    end else if (tick) begin
      bcd_d   = step_val;
      pre_d   = '0;
      carry_d = wrap;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q    <= '0;
      carry_q  <= 1'b0;
      pre_q    <= '0;
      cdiv_q   <= '0;
      lcdcom_q <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      carry_q  <= carry_d;
      pre_q    <= pre_d;
      cdiv_q   <= cdiv_d;
      lcdcom_q <= lcdcom_d;
    end
  end

  // Scan from the top digit down; a digit is blanked while everything at
  // and above it is zero.
  always_comb begin : p_seg
    logic       hi_zero;
    logic [6:0] seg;
    hi_zero = 1'b1;
    seg     = 7'h00;
    lcdseg  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      hi_zero = hi_zero & (bcd_q[4*k +: 4] == 4'd0);
      if (blank_lz && (k > 0) && hi_zero) seg = 7'h00;
      else                                seg = seg7(bcd_q[4*k +: 4]);
      lcdseg[7*k +: 7] = seg ^ {7{lcdcom_q}};
    end
  end

  assign bcd_out = bcd_q;
  assign carry   = carry_q;
  assign lcdcom  = lcdcom_q;

endmodule

// File: tb/tb_lcd_bcd_counter_drv.sv
module tb_lcd_bcd_counter_drv;

  localparam int DIGITS  = 3;
  localparam int CNT_DIV = 4;
  localparam int COM_DIV = 8;
  localparam int LW      = 4 * DIGITS;
  localparam int SW      = 7 * DIGITS;

  logic          clk = 1'b0;
  logic          rst, en, up, load, blank_lz;
  logic [LW-1:0] load_val;
  logic [LW-1:0] bcd_out;
  logic          carry, lcdcom;
  logic [SW-1:0] lcdseg;

  lcd_bcd_counter_drv #(.DIGITS(DIGITS), .CNT_DIV(CNT_DIV), .COM_DIV(COM_DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .bcd_out  (bcd_out),
    .carry    (carry),
    .lcdcom   (lcdcom),
    .lcdseg   (lcdseg)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Reference model: count held as a plain integer.
  int m_cnt   = 0;
  int m_pre   = 0;
  int m_cdiv  = 0;
  bit m_com   = 1'b0;
  bit m_carry = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clean_load(input logic [LW-1:0] lv);
    int v = 0;
    for (int k = 0; k < DIGITS; k++) begin
      logic [3:0] nib;
      nib = lv[4*k +: 4];
      if (nib <= 4'd9) v = v + int'(nib) * pow10(k);
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_bcd(input int v);
    logic [LW-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic logic [SW-1:0] exp_seg(input int v, input bit bl, input bit com);
    logic [SW-1:0] r = '0;
    logic [6:0]    s;
    for (int k = 0; k < DIGITS; k++) begin
      if (bl && k > 0 && v < pow10(k)) s = 7'h00;
      else                             s = seg_tab[(v / pow10(k)) % 10];
      r[7*k +: 7] = s ^ {7{com}};
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_cdiv = 0; m_com = 1'b0; m_carry = 1'b0;
    end else begin
      if (m_cdiv == COM_DIV - 1) begin m_cdiv = 0; m_com = ~m_com; end
      else m_cdiv = m_cdiv + 1;
      m_carry = 1'b0;
      if (load) begin
        m_cnt = clean_load(load_val);
        m_pre = 0;
      end else if (en) begin
        if (m_pre == CNT_DIV - 1) begin
          m_pre = 0;
          if (up) begin
            if (m_cnt == pow10(DIGITS) - 1) begin m_cnt = 0; m_carry = 1'b1; end
            else m_cnt = m_cnt + 1;
          end else begin
            if (m_cnt == 0) begin m_cnt = pow10(DIGITS) - 1; m_carry = 1'b1; end
            else m_cnt = m_cnt - 1;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("bcd_out", 64'(bcd_out), 64'(exp_bcd(m_cnt)));
      check("carry",   64'(carry),   64'(m_carry));
      check("lcdcom",  64'(lcdcom),  64'(m_com));
      check("lcdseg",  64'(lcdseg),  64'(exp_seg(m_cnt, blank_lz, m_com)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [LW-1:0] v);
    load = 1'b1; load_val = v;
    step(1);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; blank_lz = 1'b0;
    step(2);
    chk_en = 1'b1;

    // reset state
    check("rst_bcd",    64'(bcd_out), 64'h000);
    check("rst_carry",  64'(carry),   64'h0);
    check("rst_lcdcom", 64'(lcdcom),  64'h0);
    check("rst_seg",    64'(lcdseg),  64'({7'h3F, 7'h3F, 7'h3F}));
    blank_lz = 1'b1; #1;
    check("rst_seg_blank", 64'(lcdseg), 64'({7'h00, 7'h00, 7'h3F}));
    blank_lz = 1'b0;

    // count up 12 ticks, passing 009 -> 010
    rst = 1'b0; en = 1'b1; up = 1'b1;
    step(4 * 12);
    check("up12", 64'(bcd_out), 64'h012);

    // wrap up with one-cycle carry
    do_load(12'h998);
    check("load998", 64'(bcd_out), 64'h998);
    step(4);
    check("up999", 64'(bcd_out), 64'h999);
    step(4);
    check("wrap_up_bcd",   64'(bcd_out), 64'h000);
    check("wrap_up_carry", 64'(carry),   64'h1);
    step(1);
    check("wrap_up_carry_fall", 64'(carry), 64'h0);

    // wrap down
    do_load(12'h000);
    up = 1'b0;
    step(4);
    check("wrap_dn_bcd",   64'(bcd_out), 64'h999);
    check("wrap_dn_carry", 64'(carry),   64'h1);
    step(1);
    check("wrap_dn_carry_fall", 64'(carry), 64'h0);
    do_load(12'h100);
    step(4);
    check("dn099", 64'(bcd_out), 64'h099);

    // illegal nibbles load as 0
    do_load(12'hA5C);
    check("loadA5C", 64'(bcd_out), 64'h050);

    // load on a tick cycle wins; next tick CNT_DIV cycles later
    up = 1'b1;
    step(3);
    do_load(12'h123);
    check("load_tick_bcd",   64'(bcd_out), 64'h123);
    check("load_tick_carry", 64'(carry),   64'h0);
    step(3);
    check("load_tick_hold", 64'(bcd_out), 64'h123);
    step(1);
    check("load_tick_next", 64'(bcd_out), 64'h124);

    // segment drive with and without blanking
    en = 1'b0;
    do_load(12'h001);
    check("seg001",   64'(lcdseg), 64'({7'h3F, 7'h3F, 7'h06} ^ {21{m_com}}));
    blank_lz = 1'b1; #1;
    check("seg001_bl", 64'(lcdseg), 64'({7'h00, 7'h00, 7'h06} ^ {21{m_com}}));
    step(COM_DIV);
    check("seg001_bl_ph", 64'(lcdseg), 64'({7'h00, 7'h00, 7'h06} ^ {21{m_com}}));
    blank_lz = 1'b0;

    // enable low mid-prescale
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(10);
    check("en_hold", 64'(bcd_out), 64'h001);
    en = 1'b1;
    step(2);
    check("en_resume", 64'(bcd_out), 64'h002);

    // reset together with load mid-count
    step(5);
    rst = 1'b1; load = 1'b1; load_val = 12'h777;
    step(1);
    rst = 1'b0; load = 1'b0;
    check("rst_load_bcd", 64'(bcd_out), 64'h000);
    check("rst_load_com", 64'(lcdcom),  64'h0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) up = ~up;
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      load = ($urandom_range(0, 23) == 0);
      case ($urandom_range(0, 3))
        0:       load_val = 12'h998;
        1:       load_val = 12'h001;
        default: load_val = LW'($urandom);
      endcase
      step(1);
    end
    rst = 1'b0; load = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
